// File: rtl/button_debouncer.sv
// Pushbutton conditioner: two-flop synchronizer plus stable-count debounce FSM.
// Produces a clean pressed level and one-cycle press/release pulses.
module button_debouncer #(
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic pin_button,
    output logic level,
    output logic pressed,
    output logic released
);

    // Pin value when the button is not pressed.
    localparam logic IDLE_PIN = ACTIVE_LOW;

    // Zero and one both mean "accept on the first qualifying edge".
    localparam bit FAST = (STABLE_CYCLES <= 32'd1);

    // Count value at which the next qualifying edge is the accepting one.
    localparam logic [31:0] LAST = FAST ? 32'd0 : 32'(STABLE_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t      state;
    logic [31:0] count;
    logic        sync1;
    logic        sync2;
    logic        asserted;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
        end else begin
            sync1 <= pin_button;
            sync2 <= sync1;
        end
    end

    assign asserted = ACTIVE_LOW ? ~sync2 : sync2;

    // Debounce FSM; level and pulses are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RELEASED;
            count    <= 32'd0;
            level    <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            pressed  <= 1'b0;
            released <= 1'b0;
            unique case (state)
                RELEASED: begin
                    if (asserted) begin
                        if (FAST) begin
                            state   <= HELD;
                            count   <= 32'd0;
                            level   <= 1'b1;
                            pressed <= 1'b1;
                        end else begin
                            state <= PRESS_WAIT;
                            count <= 32'd1;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!asserted) begin
                        state <= RELEASED;
                        count <= 32'd0;
                    end else if (count >= LAST) begin
                        state   <= HELD;
                        count   <= 32'd0;
                        level   <= 1'b1;
                        pressed <= 1'b1;
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                HELD: begin
                    if (!asserted) begin
                        if (FAST) begin
                            state    <= RELEASED;
                            count    <= 32'd0;
                            level    <= 1'b0;
                            released <= 1'b1;
                        end else begin
                            state <= RELEASE_WAIT;
                            count <= 32'd1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (asserted) begin
                        state <= HELD;
                        count <= 32'd0;
                    end else if (count >= LAST) begin
                        state    <= RELEASED;
                        count    <= 32'd0;
                        level    <= 1'b0;
                        released <= 1'b1;
                    end else begin
                        count <= count + 32'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4, active-low pin.
// Every cycle compares level/pressed/released against hand-derived values.
module tb_button_debouncer;

    logic clock;
    logic reset;
    logic pin_button;
    logic level;
    logic pressed;
    logic released;

    int n_checks = 0;
    int n_fail   = 0;

    button_debouncer #(
        .STABLE_CYCLES(4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pin_button(pin_button),
        .level(level),
        .pressed(pressed),
        .released(released)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", tag, obs, exp);
        end
    endtask

    // Apply pin, take one edge, then compare all outputs.
    task automatic step(input logic p, input logic el, input logic ep,
                        input logic er, input string tag);
        pin_button = p;
        @(posedge clock);
        #1;
        check({tag, ".level"}, level, el);
        check({tag, ".pressed"}, pressed, ep);
        check({tag, ".released"}, released, er);
    endtask

    task automatic steps(input int n, input logic p, input logic el,
                         input logic ep, input logic er, input string tag);
        for (int i = 0; i < n; i++) step(p, el, ep, er, tag);
    endtask

    initial begin
        reset      = 1'b1;
        pin_button = 1'b1;

        // Reset and idle
        steps(2, 1'b1, 1'b0, 1'b0, 1'b0, "reset");
        reset = 1'b0;
        steps(20, 1'b1, 1'b0, 1'b0, 1'b0, "idle");

        // Bounce rejected: 0,0,1,0,0 then released
        step(1'b0, 1'b0, 1'b0, 1'b0, "bounce_rej");
        step(1'b0, 1'b0, 1'b0, 1'b0, "bounce_rej");
        step(1'b1, 1'b0, 1'b0, 1'b0, "bounce_rej");
        step(1'b0, 1'b0, 1'b0, 1'b0, "bounce_rej");
        step(1'b0, 1'b0, 1'b0, 1'b0, "bounce_rej");
        steps(10, 1'b1, 1'b0, 1'b0, 1'b0, "bounce_rej_tail");

        // Clean press: pulse on 6th edge
        steps(5, 1'b0, 1'b0, 1'b0, 1'b0, "press_wait");
        step(1'b0, 1'b1, 1'b1, 1'b0, "press_edge");
        steps(6, 1'b0, 1'b1, 1'b0, 1'b0, "press_hold");

        // Clean release: pulse on 6th edge
        steps(5, 1'b1, 1'b1, 1'b0, 1'b0, "rel_wait");
        step(1'b1, 1'b0, 1'b0, 1'b1, "rel_edge");
        steps(6, 1'b1, 1'b0, 1'b0, 1'b0, "rel_idle");

        // Bounce on press settles: 0,1,0,1 then 0 held
        step(1'b0, 1'b0, 1'b0, 1'b0, "settle");
        step(1'b1, 1'b0, 1'b0, 1'b0, "settle");
        step(1'b0, 1'b0, 1'b0, 1'b0, "settle");
        step(1'b1, 1'b0, 1'b0, 1'b0, "settle");
        steps(5, 1'b0, 1'b0, 1'b0, 1'b0, "settle_wait");
        step(1'b0, 1'b1, 1'b1, 1'b0, "settle_edge");
        steps(5, 1'b0, 1'b1, 1'b0, 1'b0, "settle_hold");

        // Bounce on release returns to HELD without pulses
        step(1'b1, 1'b1, 1'b0, 1'b0, "relbounce");
        step(1'b1, 1'b1, 1'b0, 1'b0, "relbounce");
        steps(8, 1'b0, 1'b1, 1'b0, 1'b0, "relbounce_hold");

        // Reset while held: clear without released pulse
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, "midreset");
        step(1'b0, 1'b0, 1'b0, 1'b0, "midreset");
        reset = 1'b0;
        steps(5, 1'b0, 1'b0, 1'b0, 1'b0, "postreset_wait");
        step(1'b0, 1'b1, 1'b1, 1'b0, "postreset_press");
        steps(3, 1'b0, 1'b1, 1'b0, 1'b0, "postreset_hold");

        // Final clean release
        steps(5, 1'b1, 1'b1, 1'b0, 1'b0, "final_wait");
        step(1'b1, 1'b0, 1'b0, 1'b1, "final_rel");
        steps(4, 1'b1, 1'b0, 1'b0, 1'b0, "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
